serial_accum_bank: RTL and testbench

SERIAL_ACCUM_BANK -- requirements
Module: serial_accum_bank

---
 rtl/serial_accum_bank.sv | 140 ++++++++++++++
 tb/tb_serial_accum_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_accum_bank.sv
// serial_accum_bank
// A bank of NUM_CH signed accumulators that run side by side. start opens a
// frame. Each accepted beat adds every lane whose mask bit is set. The frame
// closes after LEN accepted beats; the final sums are then captured into
// out_data and offered through a valid/ready handshake.
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   start      clears the sums, the beat count and ovf, then begins a frame
//   in_valid   in_data/in_mask carry a beat
//   in_ready   a beat can be accepted (high only in ACCUM)
//   in_mask    per-lane add enable for the current beat
//   in_data    signed lane samples; lane k is bits [k*DATA_W +: DATA_W]
//   out_valid  out_data holds a completed frame result
//   out_ready  the consumer takes the result
//   out_data   captured lane sums, packed like in_data
//   ovf        sticky per-lane overflow flag for the current or last frame
//   busy       high whenever the block is not IDLE
module serial_accum_bank #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    parameter int LEN    = 420,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH-1:0]        in_mask,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        ovf,
    output logic                     busy
);

    // The count only has to reach LEN, so this width can never wrap within a frame.
    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                    state, state_nxt;
    logic [NUM_CH*DATA_W-1:0]  sum_q, sum_add;
    logic [NUM_CH-1:0]         lane_ovf;
    logic [CNT_W-1:0]          cnt_q;
    logic                      clr, acc_en, cap;

    // Each lane adds in DATA_W+1 bits. A result is out of range when its top
    // two bits differ.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic [DATA_W-1:0] cur, smp, res;
        logic [DATA_W:0]   wide;

        assign cur  = sum_q[k*DATA_W +: DATA_W];
        assign smp  = in_data[k*DATA_W +: DATA_W];
        assign wide = {cur[DATA_W-1], cur} + {smp[DATA_W-1], smp};
        assign lane_ovf[k] = wide[DATA_W] ^ wide[DATA_W-1];

        always_comb begin
            res = wide[DATA_W-1:0];
            if (SAT != 0 && lane_ovf[k]) begin
                res = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
            end
        end

        assign sum_add[k*DATA_W +: DATA_W] = in_mask[k] ? res : cur;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        acc_en    = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                // A restart takes priority and drops any beat offered in the same cycle.
                if (start) begin
                    clr = 1'b1;
                end else if (in_valid) begin
                    acc_en = 1'b1;
                    if (cnt_q == LAST) begin
                        cap       = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (start) begin
                        clr       = 1'b1;
                        state_nxt = ACCUM;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= '0;
            cnt_q    <= '0;
            ovf      <= '0;
            out_data <= '0;
        end else if (clr) begin
            sum_q <= '0;
            cnt_q <= '0;
            ovf   <= '0;
        end else if (acc_en) begin
            sum_q <= sum_add;
            cnt_q <= cnt_q + CNT_W'(1);
            ovf   <= ovf | (lane_ovf & in_mask);
            // Capture the sums including the last beat, so the result is ready one cycle later.
            if (cap) out_data <= sum_add;
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_accum_bank.sv
module tb_serial_accum_bank;

    localparam int DW   = 8;
    localparam int NC   = 2;
    localparam int LEN  = 4;
    localparam int MAXV = 2**(DW-1) - 1;
    localparam int MINV = -(2**(DW-1));
    localparam int RNG  = 2**DW;

    logic clk = 1'b0;
    logic rst, start, in_valid, out_ready;
    logic [NC-1:0]    in_mask;
    logic [NC*DW-1:0] in_data;

    logic             in_ready_s, out_valid_s, busy_s;
    logic [NC*DW-1:0] out_data_s;
    logic [NC-1:0]    ovf_s;
    logic             in_ready_w, out_valid_w, busy_w;
    logic [NC*DW-1:0] out_data_w;
    logic [NC-1:0]    ovf_w;

    serial_accum_bank #(.DATA_W(DW), .NUM_CH(NC), .LEN(LEN), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_mask(in_mask), .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .ovf(ovf_s), .busy(busy_s)
    );

    serial_accum_bank #(.DATA_W(DW), .NUM_CH(NC), .LEN(LEN), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_mask(in_mask), .in_data(in_data), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data(out_data_w), .ovf(ovf_w), .busy(busy_w)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a phase (0 idle, 1 accumulating, 2 result waiting),
    // plain integer sums for the saturating and wrapping variants, and the
    // number of beats taken in the current frame.
    int            m_phase;
    int            m_beats;
    int            m_sum_s[NC], m_sum_w[NC], m_out_s[NC], m_out_w[NC];
    logic [NC-1:0] m_ovf_s, m_ovf_w;

    task automatic model_clear();
        for (int k = 0; k < NC; k++) begin
            m_sum_s[k] = 0;
            m_sum_w[k] = 0;
        end
        m_ovf_s = '0;
        m_ovf_w = '0;
        m_beats = 0;
    endtask

    task automatic model_reset();
        model_clear();
        for (int k = 0; k < NC; k++) begin
            m_out_s[k] = 0;
            m_out_w[k] = 0;
        end
        m_phase = 0;
    endtask

    function automatic int lane_val(input int k);
        logic signed [DW-1:0] v;
        v = in_data[k*DW +: DW];
        return int'(v);
    endfunction

    task automatic model_edge();
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_phase == 0) begin
            if (start) begin
                model_clear();
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (start) begin
                model_clear();
            end else if (in_valid) begin
                for (int k = 0; k < NC; k++) begin
                    if (in_mask[k]) begin
                        s = m_sum_s[k] + lane_val(k);
                        if (s > MAXV || s < MINV) m_ovf_s[k] = 1'b1;
                        m_sum_s[k] = (s > MAXV) ? MAXV : (s < MINV) ? MINV : s;
                        s = m_sum_w[k] + lane_val(k);
                        if (s > MAXV || s < MINV) m_ovf_w[k] = 1'b1;
                        m_sum_w[k] = ((s - MINV) % RNG + RNG) % RNG + MINV;
                    end
                end
                m_beats++;
                if (m_beats == LEN) begin
                    m_out_s = m_sum_s;
                    m_out_w = m_sum_w;
                    m_phase = 2;
                end
            end
        end else begin
            if (out_ready) begin
                if (start) begin
                    model_clear();
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [NC*DW-1:0] e_s, e_w;
        for (int k = 0; k < NC; k++) begin
            e_s[k*DW +: DW] = m_out_s[k][DW-1:0];
            e_w[k*DW +: DW] = m_out_w[k][DW-1:0];
        end
        check("in_ready_s",  32'(in_ready_s),  32'(m_phase == 1));
        check("out_valid_s", 32'(out_valid_s), 32'(m_phase == 2));
        check("busy_s",      32'(busy_s),      32'(m_phase != 0));
        check("ovf_s",       32'(ovf_s),       32'(m_ovf_s));
        check("out_data_s",  32'(out_data_s),  32'(e_s));
        check("in_ready_w",  32'(in_ready_w),  32'(m_phase == 1));
        check("out_valid_w", 32'(out_valid_w), 32'(m_phase == 2));
        check("busy_w",      32'(busy_w),      32'(m_phase != 0));
        check("ovf_w",       32'(ovf_w),       32'(m_ovf_w));
        check("out_data_w",  32'(out_data_w),  32'(e_w));
    endtask

    // Inputs are driven 1 time unit after a rising edge. The model advances
    // with those inputs, and the outputs are compared 1 unit after the next edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [NC-1:0] m, input int l0, input int l1);
        in_valid = 1'b1;
        in_mask  = m;
        in_data  = {l1[DW-1:0], l0[DW-1:0]};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mask = '0; in_data = '0;
        model_reset();
        #1;
        compare();
        tick();
        rst = 1'b0;
        tick();

        // basic frame
        do_start();
        beat(2'b11, 1, -1);
        beat(2'b11, 2, -2);
        beat(2'b11, 3, -3);
        check("basic_early_valid", 32'(out_valid_s), 32'd0);
        beat(2'b11, 4, -4);
        check("basic_valid", 32'(out_valid_s), 32'd1);
        check("basic_data",  32'(out_data_s), 32'h0000F60A);
        check("basic_ovf",   32'(ovf_s), 32'd0);
        release_result();

        // saturation versus wrap
        do_start();
        beat(2'b01, 100, 0);
        beat(2'b01, 100, 0);
        beat(2'b01, 0, 0);
        beat(2'b01, 0, 0);
        check("sat_lane0",  32'(out_data_s[7:0]), 32'h7F);
        check("wrap_lane0", 32'(out_data_w[7:0]), 32'hC8);
        check("sat_ovf0",   32'(ovf_s[0]), 32'd1);
        check("wrap_ovf0",  32'(ovf_w[0]), 32'd1);
        release_result();

        // mask, then backpressure while beats keep arriving
        do_start();
        beat(2'b11, 1, 5);
        beat(2'b01, 1, 5);
        beat(2'b01, 1, 5);
        beat(2'b11, 1, 5);
        check("mask_lane1", 32'(out_data_s[15:8]), 32'd10);
        check("mask_valid", 32'(out_valid_s), 32'd1);
        in_valid = 1'b1; in_mask = 2'b11; in_data = 16'h0303;
        for (int i = 0; i < 5; i++) tick();
        check("bp_ready", 32'(in_ready_s), 32'd0);
        check("bp_valid", 32'(out_valid_s), 32'd1);
        check("bp_data",  32'(out_data_s), 32'h00000A04);
        in_valid = 1'b0;
        release_result();
        check("bp_idle", 32'(busy_s), 32'd0);

        // restart with a discarded beat in the restart cycle
        do_start();
        beat(2'b11, 7, 7);
        beat(2'b11, 7, 7);
        start = 1'b1; in_valid = 1'b1; in_mask = 2'b11; in_data = 16'h0909;
        tick();
        start = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) beat(2'b11, 1, 1);
        check("restart_data", 32'(out_data_s), 32'h00000404);
        release_result();

        // asynchronous reset in the middle of a frame
        do_start();
        for (int i = 0; i < 3; i++) beat(2'b11, 20, -20);
        #2 rst = 1'b1;
        #1;
        check("rst_busy",  32'(busy_s), 32'd0);
        check("rst_ready", 32'(in_ready_s), 32'd0);
        check("rst_valid", 32'(out_valid_s), 32'd0);
        check("rst_data",  32'(out_data_s), 32'd0);
        check("rst_ovf",   32'(ovf_s), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        beat(2'b11, 1, 1);
        check("rst_no_valid", 32'(out_valid_s), 32'd0);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            start     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mask   = NC'($urandom);
            in_data   = (NC*DW)'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
